// File: rtl/oled_source_arbiter.sv
// oled_source_arbiter: debounced, frame-synchronised priority selector for the
// OLED pixel path. The highest-index debounced request wins; a new source is
// only committed on a frame-begin strobe, so the panel never shows a frame
// stitched from two sources.
// Build option: define OLED_ARB_BLANK_EN to insert BLANK_FRAMES blank frames
// between sources; left undefined, a commit goes straight to the new source.
module oled_source_arbiter #(
  parameter int               NUM_SRC         = 4,
  parameter int               PIX_W           = 16,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               BLANK_FRAMES    = 2,
  parameter logic [PIX_W-1:0] BLANK_COLOUR    = 16'h0000
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         sel_req,
  input  logic                       frame_begin,
  input  logic [NUM_SRC*PIX_W-1:0]   pixel_in,
  output logic [PIX_W-1:0]           pixel_out,
  output logic [$clog2(NUM_SRC)-1:0] active_src,
  output logic                       active_valid,
  output logic                       switch_pending
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (NUM_SRC < 2 || NUM_SRC > 16 || DEBOUNCE_CYCLES < 2 || BLANK_FRAMES < 1) begin : g_param_check
    $error("oled_source_arbiter: parameter out of range");
  end

`ifdef OLED_ARB_BLANK_EN
  localparam int FR_W = $clog2(BLANK_FRAMES + 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(BLANK_FRAMES - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_LIVE, ST_PENDING, ST_BLANK} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_LIVE, ST_PENDING} state_t;
`endif

  // invalid selections compare equal regardless of the index they carry
  function automatic logic f_differs(input logic a_v, input logic [SRC_W-1:0] a_s,
                                     input logic b_v, input logic [SRC_W-1:0] b_s);
    return (a_v != b_v) || (a_v && (a_s != b_s));
  endfunction

  logic [NUM_SRC-1:0] r_req_s1, r_req_s2, r_deb;
  logic [CNT_W-1:0]   r_deb_cnt [NUM_SRC];
  logic               r_fb_s1, r_fb_s2, r_fb_s3, r_fb;
  state_t             r_state, w_state_nxt;
  logic [SRC_W-1:0]   r_active_src, w_active_src_nxt;
  logic               r_active_valid, w_active_valid_nxt;
  logic [SRC_W-1:0]   r_tgt_src, w_tgt_src_nxt;
  logic               r_tgt_valid, w_tgt_valid_nxt;
  logic [PIX_W-1:0]   r_pixel;
  logic [SRC_W-1:0]   w_cand;
  logic               w_cand_valid;
  logic               w_cand_diff;
  logic [PIX_W-1:0]   w_pix [NUM_SRC];
`ifdef OLED_ARB_BLANK_EN
  logic [FR_W-1:0]    r_frame_cnt, w_frame_nxt;
`endif

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_pix
    assign w_pix[g] = pixel_in[g*PIX_W +: PIX_W];
  end

  // synchronise the request switches and debounce each bit independently
  always_ff @(posedge clock) begin
    if (rst) begin
      r_req_s1 <= '0;
      r_req_s2 <= '0;
      r_deb    <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_req_s1 <= sel_req;
      r_req_s2 <= r_req_s1;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (r_req_s2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == CNT_LAST) begin
          r_deb[i]     <= r_req_s2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // synchronise frame_begin and turn its rising edge into a registered strobe
  always_ff @(posedge clock) begin
    if (rst) begin
      r_fb_s1 <= 1'b0;
      r_fb_s2 <= 1'b0;
      r_fb_s3 <= 1'b0;
      r_fb    <= 1'b0;
    end else begin
      r_fb_s1 <= frame_begin;
      r_fb_s2 <= r_fb_s1;
      r_fb_s3 <= r_fb_s2;
      r_fb    <= r_fb_s2 & ~r_fb_s3;
    end
  end

  // priority encoder: highest debounced index wins
  always_comb begin
    w_cand       = '0;
    w_cand_valid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_deb[i]) begin
        w_cand       = SRC_W'(i);
        w_cand_valid = 1'b1;
      end
    end
  end

  assign w_cand_diff = f_differs(w_cand_valid, w_cand, r_active_valid, r_active_src);

  // next state, target tracking and commit decisions
  always_comb begin
    w_state_nxt        = r_state;
    w_active_src_nxt   = r_active_src;
    w_active_valid_nxt = r_active_valid;
    w_tgt_src_nxt      = r_tgt_src;
    w_tgt_valid_nxt    = r_tgt_valid;
`ifdef OLED_ARB_BLANK_EN
    w_frame_nxt        = r_frame_cnt;
`endif
    case (r_state)
      ST_IDLE, ST_LIVE: begin
        w_tgt_src_nxt   = w_cand;
        w_tgt_valid_nxt = w_cand_valid;
        if (w_cand_diff) w_state_nxt = ST_PENDING;
      end
      ST_PENDING: begin
        if (r_fb) begin
          // commit the target held before this cycle; a candidate change
          // arriving together with the strobe is picked up next frame
          if (!r_tgt_valid) begin
            w_state_nxt        = ST_IDLE;
            w_active_valid_nxt = 1'b0;
          end else begin
            w_active_src_nxt   = r_tgt_src;
`ifdef OLED_ARB_BLANK_EN
            w_active_valid_nxt = 1'b0;
            w_frame_nxt        = '0;
            w_state_nxt        = ST_BLANK;
`else
            w_active_valid_nxt = 1'b1;
            w_state_nxt        = ST_LIVE;
`endif
          end
        end else begin
          w_tgt_src_nxt   = w_cand;
          w_tgt_valid_nxt = w_cand_valid;
          if (!w_cand_diff) w_state_nxt = r_active_valid ? ST_LIVE : ST_IDLE;
        end
      end
`ifdef OLED_ARB_BLANK_EN
      ST_BLANK: begin
        if (r_fb) begin
          if (r_frame_cnt == FR_LAST) begin
            w_active_valid_nxt = 1'b1;
            w_state_nxt        = ST_LIVE;
          end else begin
            w_frame_nxt = r_frame_cnt + 1'b1;
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // state, committed selection, target and registered pixel
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_active_src   <= '0;
      r_active_valid <= 1'b0;
      r_tgt_src      <= '0;
      r_tgt_valid    <= 1'b0;
      r_pixel        <= BLANK_COLOUR;
    end else begin
      r_state        <= w_state_nxt;
      r_active_src   <= w_active_src_nxt;
      r_active_valid <= w_active_valid_nxt;
      r_tgt_src      <= w_tgt_src_nxt;
      r_tgt_valid    <= w_tgt_valid_nxt;
      r_pixel        <= w_active_valid_nxt ? w_pix[w_active_src_nxt] : BLANK_COLOUR;
    end
  end

`ifdef OLED_ARB_BLANK_EN
  // blank-frame counter
  always_ff @(posedge clock) begin
    if (rst) r_frame_cnt <= '0;
    else     r_frame_cnt <= w_frame_nxt;
  end
`endif

  assign pixel_out      = r_pixel;
  assign active_src     = r_active_src;
  assign active_valid   = r_active_valid;
  assign switch_pending = f_differs(r_tgt_valid, r_tgt_src, r_active_valid, r_active_src);

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Testbench for oled_source_arbiter: directed scenarios followed by random
// request/frame/reset traffic, every cycle compared against a reference model.
module tb_oled_source_arbiter;

  localparam int NUM_SRC = 4;
  localparam int PIX_W   = 16;
  localparam int DEB     = 4;
  localparam int BFRAMES = 2;
`ifdef OLED_ARB_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic                     clock = 1'b0;
  logic                     rst;
  logic [NUM_SRC-1:0]       sel_req;
  logic                     frame_begin;
  logic [NUM_SRC*PIX_W-1:0] pixel_in;
  logic [PIX_W-1:0]         pixel_out;
  logic [1:0]               active_src;
  logic                     active_valid;
  logic                     switch_pending;

  oled_source_arbiter #(
    .NUM_SRC(NUM_SRC), .PIX_W(PIX_W), .DEBOUNCE_CYCLES(DEB),
    .BLANK_FRAMES(BFRAMES), .BLANK_COLOUR(16'h0000)
  ) dut (
    .clock(clock), .rst(rst), .sel_req(sel_req), .frame_begin(frame_begin),
    .pixel_in(pixel_in), .pixel_out(pixel_out), .active_src(active_src),
    .active_valid(active_valid), .switch_pending(switch_pending)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: input histories, debounced levels, committed/target pair
  bit [3:0] m_req_h [3];
  bit       m_fb_h  [5];
  bit [3:0] m_deb;
  int       m_run [4];
  bit       m_av, m_tv, m_pend, m_blank;
  int       m_as, m_ts, m_frames;

  function automatic bit sel_differs(bit av, int as, bit bv, int bs);
    return (av != bv) || (av && (as != bs));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_req_h[i] = '0;
    for (int i = 0; i < 5; i++) m_fb_h[i] = 1'b0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_deb = '0; m_av = 0; m_as = 0; m_tv = 0; m_ts = 0;
    m_pend = 0; m_blank = 0; m_frames = 0;
  endtask

  // advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit       fb;
    bit [3:0] synced;
    bit       cv;
    int       cs;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 2; i > 0; i--) m_req_h[i] = m_req_h[i-1];
    m_req_h[0] = sel_req;
    for (int i = 4; i > 0; i--) m_fb_h[i] = m_fb_h[i-1];
    m_fb_h[0] = frame_begin;
    fb     = m_fb_h[3] & ~m_fb_h[4];
    synced = m_req_h[2];
    cv = 0; cs = 0;
    for (int i = 0; i < 4; i++) if (m_deb[i]) begin cv = 1; cs = i; end

    if (m_blank) begin
      if (fb) begin
        m_frames++;
        if (m_frames == BFRAMES) begin m_blank = 0; m_av = 1; end
      end
    end else if (m_pend) begin
      if (fb) begin
        m_pend = 0;
        if (!m_tv) m_av = 0;
        else begin
          m_as = m_ts;
          if (BLANK_EN) begin m_av = 0; m_blank = 1; m_frames = 0; end
          else m_av = 1;
        end
      end else begin
        m_tv = cv; m_ts = cs;
        if (!sel_differs(cv, cs, m_av, m_as)) m_pend = 0;
      end
    end else begin
      m_tv = cv; m_ts = cs;
      if (sel_differs(cv, cs, m_av, m_as)) m_pend = 1;
    end

    for (int i = 0; i < 4; i++) begin
      if (synced[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_deb[i] = synced[i]; m_run[i] = 0; end
      end else m_run[i] = 0;
    end
  endtask

  bit frames_on = 0;
  int flen = 16;
  int fcnt = 0;

  task automatic tick();
    frame_begin = frames_on ? ((fcnt % flen) < (flen / 2)) : 1'b0;
    fcnt++;
    model_step();
    @(posedge clock);
    #1;
    check_eq("pixel_out", pixel_out, m_av ? 32'h1111 * (m_as + 1) : 32'h0);
    check_eq("active_src", active_src, m_as);
    check_eq("active_valid", active_valid, m_av);
    check_eq("switch_pending", switch_pending, sel_differs(m_tv, m_ts, m_av, m_as));
  endtask

  initial begin
    int n;
    int hold;
    rst = 1; sel_req = '0; frame_begin = 0;
    pixel_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    model_reset();
    repeat (3) tick();
    check_eq("reset_pixel", pixel_out, 16'h0000);
    check_eq("reset_pending", switch_pending, 0);
    rst = 0;

    // idle with frames running
    frames_on = 1;
    repeat (60) tick();
    check_eq("idle_valid", active_valid, 0);
    check_eq("idle_pixel", pixel_out, 16'h0000);

    // short glitch must not reach the debounced vector
    sel_req = 4'b0001;
    repeat (3) tick();
    sel_req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("glitch_pending", switch_pending, 0);
    end

    // acquire source 0
    sel_req = 4'b0001;
    n = 0;
    do begin tick(); n++; end while (!switch_pending && n < 40);
    check_eq("pend_latency", n, 7);
    n = 0;
    while (!active_valid && n < 200) begin tick(); n++; end
    check_eq("acq0_valid", active_valid, 1);
    check_eq("acq0_pixel", pixel_out, 16'h1111);

    // request source 3 with frames stopped: output must hold
    frames_on = 0;
    repeat (4) tick();
    sel_req = 4'b1001;
    repeat (12) tick();
    check_eq("hold_pending", switch_pending, 1);
    check_eq("hold_pixel", pixel_out, 16'h1111);
    frames_on = 1;
    n = 0;
    while (!(active_valid && active_src == 2'd3) && n < 200) begin tick(); n++; end
    check_eq("acq3_src", active_src, 3);
    check_eq("acq3_pixel", pixel_out, 16'h4444);

    // back to source 0, then abort a pending switch to 3
    sel_req = 4'b0001;
    n = 0;
    while (!(active_valid && active_src == 2'd0) && n < 200) begin tick(); n++; end
    check_eq("back0_pixel", pixel_out, 16'h1111);
    frames_on = 0;
    repeat (4) tick();
    sel_req = 4'b1001;
    repeat (10) tick();
    check_eq("abort_pending_hi", switch_pending, 1);
    sel_req = 4'b0001;
    repeat (10) tick();
    check_eq("abort_pending_lo", switch_pending, 0);
    frames_on = 1;
    repeat (60) tick();
    check_eq("abort_keep_pixel", pixel_out, 16'h1111);

    // reset in the middle of a switch
    sel_req = 4'b1001;
    n = 0;
    while (!(active_src == 2'd3 && active_valid == !BLANK_EN) && n < 200) begin tick(); n++; end
    check_eq("mid_switch_reached", active_src, 3);
    rst = 1; sel_req = 4'b0001;
    tick();
    check_eq("rst_pixel", pixel_out, 16'h0000);
    check_eq("rst_src", active_src, 0);
    check_eq("rst_valid", active_valid, 0);
    check_eq("rst_pending", switch_pending, 0);
    rst = 0;
    n = 0;
    do begin tick(); n++; end while (!switch_pending && n < 40);
    check_eq("rst_pend_latency", n, 7);
    n = 0;
    while (!active_valid && n < 200) begin tick(); n++; end
    check_eq("reacq_pixel", pixel_out, 16'h1111);

    // random traffic
    for (int ph = 0; ph < 3; ph++) begin
      flen = 8 + 4 * $urandom_range(0, 2);
      hold = 0;
      for (int c = 0; c < 600; c++) begin
        if (hold == 0) begin
          sel_req = 4'($urandom_range(0, 15));
          hold = $urandom_range(1, 14);
        end
        hold--;
        rst = ($urandom_range(0, 399) == 0);
        tick();
      end
      rst = 0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/oled_source_arbiter.md
# oled_source_arbiter

Parametrised, frame-synchronised selector for the OLED pixel path. It replaces the fixed switch-priority mux between the per-task `oled_data` sources. It debounces one request line per source and picks the highest-priority active request. The switch to a new source happens only at a display frame boundary, with optional blank frames between sources. It sits between the task renderers and `Oled_Display.pixel_data`, in the 100 MHz `clock` domain.

## Interface
- `NUM_SRC`, 4: number of pixel sources/request lines (2..16).
- `PIX_W`, 16: pixel width, RGB565.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable `clock` cycles before a request change is accepted (≥2).
- `BLANK_FRAMES`, 2: blank frames inserted per switch (≥1; used only with the blank feature).
- `BLANK_COLOUR`, 16'h0000: pixel value driven while blanking or with no source.

Ports:
- `clock`  in  1  system clock, 100 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `sel_req`  in  NUM_SRC  raw request lines (switches), asynchronous; bit i requests source i.
- `frame_begin`  in  1  level from the `Oled_Display` 6.25 MHz domain; synchronised internally.
- `pixel_in`  in  NUM_SRC*PIX_W  source i occupies bits [i*PIX_W +: PIX_W].
- `pixel_out`  out  PIX_W  selected pixel, registered.
- `active_src`  out  clog2(NUM_SRC)  index of committed source.
- `active_valid`  out  1  a source is committed and live.
- `switch_pending`  out  1  debounced selection differs from committed state.

## Operation
- Each `sel_req` bit passes a 2-flop synchroniser, then its own debounce counter.
- The debounced bit toggles only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles. Any return to the old value clears the counter.
- Priority encoder on the debounced vector: highest index wins. The output is `cand`/`cand_valid`; `cand_valid=0` when no bit is set.
- `frame_begin` is synchronised with 2 flops. Its rising edge produces the 1-cycle strobe `fb`.
- FSM states:
  - IDLE: no source; output `BLANK_COLOUR`.
  - LIVE: output `pixel_in[active_src]`.
  - PENDING: still outputting the current state; waiting for `fb`.
  - BLANK: output `BLANK_COLOUR` for `BLANK_FRAMES` `fb` strobes.
- FSM transitions:
  - IDLE/LIVE → PENDING when `{cand_valid,cand}` ≠ committed `{active_valid,active_src}`.
  - PENDING → IDLE/LIVE without committing if the candidate returns to the committed value before `fb`.
  - PENDING while the candidate changes to a different value: the target tracks the latest candidate.
  - PENDING on `fb`, with `cand_valid=0`: → IDLE; `active_valid` goes 0, `active_src` holds.
  - PENDING on `fb`, with `cand_valid=1`: `active_src` takes the target, `active_valid` goes 0, state → BLANK with the frame counter set to 0.
  - BLANK: each `fb` increments the frame counter. On the strobe that reaches `BLANK_FRAMES`, `active_valid` goes 1 and state → LIVE.
  - A candidate change during BLANK is not acted on until LIVE is reached. It then enters PENDING normally.
- `fb` in the same cycle as a candidate change: the commit uses the target registered before that cycle. The new candidate is handled at the next frame.
- `switch_pending` = 1 whenever the registered target differs from the committed state, in any state.

## Timing
- Reset values: state IDLE, `pixel_out`=`BLANK_COLOUR`, `active_src`=0, `active_valid`=0, `switch_pending`=0.
- Reset values of internals: debounced vector 0, all counters 0, synchroniser flops 0.
- `rst` mid-operation overrides every transition in that cycle.
- `pixel_out` latency: 1 `clock` cycle from `pixel_in`/state. There is no combinational path input→output.
- Request latency from a `sel_req` edge to the debounced change: 2 (synchroniser) + `DEBOUNCE_CYCLES` cycles.
- Debounced change → `switch_pending` high: 1 cycle.
- `frame_begin` rising edge → `fb`: 3 cycles.
- `fb` → committed state and output change: 1 cycle.
- Outputs never change source mid-frame. All commits occur on an `fb` cycle.

## Configuration
- `OLED_ARB_BLANK_EN` defined: the BLANK state and frame counter are present; behaviour is as above.
- `OLED_ARB_BLANK_EN` undefined:
  - No BLANK state and no frame counter; `BLANK_FRAMES` is ignored.
  - PENDING on `fb` with a valid target goes directly to LIVE, with `active_valid`=1 in the same update.
  - IDLE handling is unchanged.

## Test plan
Bench parameters for all cases: `NUM_SRC`=4, `DEBOUNCE_CYCLES`=4, `BLANK_FRAMES`=2, `pixel_in[i]`=16'h1111*(i+1).
- Reset, all `sel_req`=0, toggle `frame_begin` → `pixel_out`=0000, `active_valid`=0, `switch_pending`=0 throughout.
- `sel_req`=4'b0001 with frames running → `switch_pending` rises 7 cycles after the edge; `pixel_out` goes 0000 on the 1st `fb`.
  - With the macro: `pixel_out`=1111 and `active_valid`=1 after the 3rd `fb`.
  - Without the macro: this happens after the 1st `fb`.
- `sel_req` glitch 0→1 for 3 cycles, then back to 0 → no debounced change; `switch_pending` stays 0.
- From LIVE on source 0, set `sel_req`=4'b1001 → target 3; `pixel_out` stays 1111 until `fb`, then switches to blank and then 4444.
  - The output never changes between strobes.
- In PENDING toward source 3, drop bit 3 before `fb` → `switch_pending` falls; source 0 stays live with no blank frames.
- Assert `rst` during BLANK → next cycle all outputs hold their reset values; after release, re-acquire source 0 per the second scenario.
